// File: rtl/cva6_axi_txn_regulator.sv
// AXI outstanding-transaction regulator: throttles AW/AR issue and drains on quiesce.
// Optional stall watchdog enabled by defining CVA6_AXI_TXN_WDOG_EN.
module cva6_axi_txn_regulator #(
  parameter int unsigned MAX_WR_OUTSTANDING = 8,
  parameter int unsigned MAX_RD_OUTSTANDING = 8,
  parameter int unsigned WDOG_CYCLES        = 65535
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       aw_valid_i,
  output logic       aw_ready_o,
  output logic       aw_valid_o,
  input  logic       aw_ready_i,
  input  logic       ar_valid_i,
  output logic       ar_ready_o,
  output logic       ar_valid_o,
  input  logic       ar_ready_i,
  input  logic       b_valid_i,
  input  logic       b_ready_i,
  input  logic       r_valid_i,
  input  logic       r_ready_i,
  input  logic       r_last_i,
  input  logic       quiesce_req_i,
  output logic       quiesced_o,
  output logic [7:0] wr_outstanding_o,
  output logic [7:0] rd_outstanding_o,
  output logic       protocol_err_o
`ifdef CVA6_AXI_TXN_WDOG_EN
  ,
  output logic       wdog_timeout_o
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] DRAIN    = 2'd1;
  localparam logic [1:0] QUIESCED = 2'd2;

  localparam logic [7:0] WR_MAX = 8'(MAX_WR_OUTSTANDING);
  localparam logic [7:0] RD_MAX = 8'(MAX_RD_OUTSTANDING);

  logic [1:0] state_q, state_d;
  logic [7:0] wr_cnt_q, wr_cnt_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic       aw_cmt_q, aw_cmt_d;
  logic       ar_cmt_q, ar_cmt_d;
  logic       err_q, err_d;

  logic aw_hs, ar_hs, b_hs, r_hs;
  logic allow_aw, allow_ar;
  logic aw_en, ar_en;
  logic drained;
  logic force_q;

  assign b_hs = b_valid_i & b_ready_i;
  assign r_hs = r_valid_i & r_ready_i & r_last_i;

  // Limit checks use registered counts only, so B/R never reach AW/AR combinationally.
  assign allow_aw = (wr_cnt_q < WR_MAX) & (state_q == RUN);
  assign allow_ar = (rd_cnt_q < RD_MAX) & (state_q == RUN);

  // A valid already presented to downstream stays enabled until it handshakes.
  assign aw_en = allow_aw | aw_cmt_q;
  assign ar_en = allow_ar | ar_cmt_q;

  assign aw_valid_o = aw_valid_i & aw_en;
  assign aw_ready_o = aw_ready_i & aw_en;
  assign ar_valid_o = ar_valid_i & ar_en;
  assign ar_ready_o = ar_ready_i & ar_en;

  assign aw_hs = aw_valid_o & aw_ready_i;
  assign ar_hs = ar_valid_o & ar_ready_i;

  assign aw_cmt_d = aw_valid_o & ~aw_ready_i;
  assign ar_cmt_d = ar_valid_o & ~ar_ready_i;

  assign drained = (wr_cnt_q == 8'd0) & (rd_cnt_q == 8'd0)
                 & ~aw_cmt_q & ~ar_cmt_q;

  assign quiesced_o       = (state_q == QUIESCED);
  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;
  assign protocol_err_o   = err_q;

  // Outstanding counters with saturation and sticky error on under/overflow.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q;
    if (aw_hs & ~b_hs) begin
      if (wr_cnt_q == 8'hff) err_d = 1'b1;
      else                   wr_cnt_d = wr_cnt_q + 8'd1;
    end else if (b_hs & ~aw_hs) begin
      if (wr_cnt_q == 8'd0) err_d = 1'b1;
      else                  wr_cnt_d = wr_cnt_q - 8'd1;
    end
    if (ar_hs & ~r_hs) begin
      if (rd_cnt_q == 8'hff) err_d = 1'b1;
      else                   rd_cnt_d = rd_cnt_q + 8'd1;
    end else if (r_hs & ~ar_hs) begin
      if (rd_cnt_q == 8'd0) err_d = 1'b1;
      else                  rd_cnt_d = rd_cnt_q - 8'd1;
    end
  end

  // Quiesce sequencing: RUN -> DRAIN -> QUIESCED, back to RUN on release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (quiesce_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!quiesce_req_i)          state_d = RUN;
        else if (drained | force_q)  state_d = QUIESCED;
      end
      QUIESCED: begin
        if (!quiesce_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Core state registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= RUN;
      wr_cnt_q <= 8'd0;
      rd_cnt_q <= 8'd0;
      aw_cmt_q <= 1'b0;
      ar_cmt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      aw_cmt_q <= aw_cmt_d;
      ar_cmt_q <= ar_cmt_d;
      err_q    <= err_d;
    end
  end

`ifdef CVA6_AXI_TXN_WDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES);

  logic [15:0] stall_q, stall_d;
  logic        wdog_q, wdog_d;
  logic        busy;

  assign busy = (wr_cnt_q != 8'd0) | (rd_cnt_q != 8'd0);

  // Stall counter: runs while work is pending and no response retires.
  always_comb begin
    stall_d = stall_q;
    wdog_d  = wdog_q | (stall_q >= WDOG_LIM);
    if (b_hs | r_hs | ~busy)       stall_d = 16'd0;
    else if (stall_q != 16'hffff)  stall_d = stall_q + 16'd1;
  end

  // Watchdog registers; timeout is sticky until reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_q <= 16'd0;
      wdog_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      wdog_q  <= wdog_d;
    end
  end

  assign force_q        = wdog_q;
  assign wdog_timeout_o = wdog_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign force_q     = 1'b0;
`endif

endmodule

// File: doc/cva6_axi_txn_regulator.md
Name: cva6_axi_txn_regulator

Overview:
- Sideband handshake controller placed between the CVA6 core AXI master and the AXI cut / Xilinx-style m_axi_cpu port in the FPGA wrapper.
- Observes AW/AR/B/R handshakes and counts outstanding write and read transactions per direction.
- Throttles new AW/AR issue at a configurable limit.
- Implements a quiesce protocol (block new requests, drain, report idle) used before reset or clock changes of the downstream fabric.
- Payload signals (addr, id, data, W channel) bypass this block and are not touched.

Parameters:
- MAX_WR_OUTSTANDING, 8, maximum in-flight write transactions (AW accepted, B not yet accepted); range 1..255.
- MAX_RD_OUTSTANDING, 8, maximum in-flight read transactions (AR accepted, last R not yet accepted); range 1..255.
- WDOG_CYCLES, 65535, stall-watchdog threshold in cycles; used only with the optional feature.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- aw_valid_i  in  1  AW valid from core
- aw_ready_o  out  1  AW ready to core
- aw_valid_o  out  1  AW valid to downstream
- aw_ready_i  in  1  AW ready from downstream
- ar_valid_i / ar_ready_o / ar_valid_o / ar_ready_i  same as AW, for AR
- b_valid_i  in  1  B valid (monitor only)
- b_ready_i  in  1  B ready (monitor only)
- r_valid_i  in  1  R valid (monitor only)
- r_ready_i  in  1  R ready (monitor only)
- r_last_i  in  1  R last (monitor only)
- quiesce_req_i  in  1  level request to drain and hold idle
- quiesced_o  out  1  drained: no outstanding transactions, new requests blocked
- wr_outstanding_o  out  8  current write count
- rd_outstanding_o  out  8  current read count
- protocol_err_o  out  1  sticky: response handshake with count 0, or count overflow

Behaviour:
- Handshake definitions:
  - aw_hs = aw_valid_o & aw_ready_i
  - ar_hs = ar_valid_o & ar_ready_i
  - b_hs = b_valid_i & b_ready_i
  - r_hs = r_valid_i & r_ready_i & r_last_i
- Write counter:
  - aw_hs only: +1.
  - b_hs only: −1.
  - Both in the same cycle: unchanged.
- Read counter: same rules with ar_hs / r_hs.
- Allow logic:
  - allow_aw = (wr_cnt < MAX_WR_OUTSTANDING) & (state==RUN).
  - allow_ar is the same with rd_cnt / MAX_RD_OUTSTANDING.
  - The check uses the registered counter, so there is no combinational path from b/r inputs to aw/ar outputs.
- AXI stability rule:
  - Flop aw_committed is set when aw_valid_o=1 and aw_ready_i=0, and cleared on aw_hs.
  - Gate enable = allow_aw | aw_committed.
  - aw_valid_o = aw_valid_i & en; aw_ready_o = aw_ready_i & en.
  - A presented valid is therefore never withdrawn by throttling or a quiesce request.
  - ar_committed behaves identically.
- State machine:
  - RUN: quiesce_req_i=1 → DRAIN.
  - DRAIN: new AW/AR blocked except committed ones. When wr_cnt==0, rd_cnt==0, and no committed flag is set → QUIESCED. quiesce_req_i=0 → RUN.
  - QUIESCED: quiesced_o=1, requests blocked. quiesce_req_i=0 → RUN on the next cycle.
- Latency: quiesced_o asserts 1 cycle after the last drain condition is met; release is 1 cycle after request deassert.
- Errors (protocol_err_o is sticky until reset):
  - b_hs with wr_cnt==0 and no simultaneous aw_hs: counter saturates at 0, error set.
  - Same rule applies to r_hs on the read side.
  - Increment at 255: counter saturates, error set.
- Reset values: all counters 0, state RUN, committed flags 0, quiesced_o 0, protocol_err_o 0.
- Outputs: aw_valid_o/ar_valid_o follow their inputs combinationally; the ready outputs follow aw_ready_i/ar_ready_i.
- Reset asserted mid-transaction: all state clears asynchronously. The downstream fabric is reset by the same aresetn.

Optional Feature:
- Macro: CVA6_AXI_TXN_WDOG_EN.
- When defined:
  - A 16-bit stall counter increments each cycle in which (wr_cnt|rd_cnt)!=0 and no b_hs/r_hs occurs.
  - It clears on any b_hs/r_hs or when both counts are 0.
  - On reaching WDOG_CYCLES, extra output port wdog_timeout_o (1 bit, sticky until reset) asserts, and DRAIN forces QUIESCED regardless of counts.
- When undefined: the port, counter, and forced transition are absent.

Test Plan:
- Throttle: MAX_WR=2, issue 3 AWs with downstream always ready, no B returned → 2 aw_hs; third AW blocked (aw_ready_o=0). One b_hs → third accepted the following cycle; wr_outstanding_o=2.
- Simultaneous: wr_cnt=1, aw_hs and b_hs in the same cycle → wr_outstanding_o stays 1.
- Stability: ar_valid_i=1, ar_ready_i=0 for 3 cycles, quiesce_req_i asserted in cycle 1 → ar_valid_o stays 1 until ar_hs, then rd_cnt=1. DRAIN holds until r_last handshake, then quiesced_o=1 one cycle later.
- Quiesce release: in QUIESCED, deassert quiesce_req_i → quiesced_o=0 and aw_ready_o follows aw_ready_i next cycle.
- Error: b_hs with wr_cnt=0 → protocol_err_o=1 and stays 1; wr_outstanding_o=0.
- Watchdog (macro on, WDOG_CYCLES=16): 1 read outstanding with no R for 16 cycles → wdog_timeout_o=1; with quiesce requested → QUIESCED despite rd_cnt=1.
